// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the timer sequencer: controller state encoding.
package timer_sequencer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/timer_sequencer_stage_counter.sv
// Up-counter stage that wraps to zero when it reaches its programmed top.
// The wrap flag is combinational and only asserted on an enabled count,
// so it can directly enable the next stage in the chain.
module timer_stage_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] top,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] r_cnt;

  assign wrap = en && (r_cnt == top);
  assign cnt  = r_cnt;

  // Count on enable, wrap at top; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Two-stage timer controller: prescaler feeds a period counter; the top
// holds the IDLE/RUN FSM, the latched configuration, the repeat counter
// and the registered tick/done pulses.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int BITS     = 16,
  parameter int PRE_BITS = 8,
  parameter int REP_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITS-1:0]     cfg_period,
  input  logic [PRE_BITS-1:0] cfg_prescale,
  input  logic [REP_BITS-1:0] cfg_repeat,
  input  logic                cfg_periodic,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  output logic                busy,
  output logic                tick,
  output logic                done,
  output logic [BITS-1:0]     count_out,
  output logic [REP_BITS-1:0] rep_left
);

  logic [0:0]          r_state;
  logic [BITS-1:0]     r_period_top;
  logic [PRE_BITS-1:0] r_pre_top;
  logic                r_periodic;
  logic [REP_BITS-1:0] r_rep_left;
  logic                r_busy;
  logic                r_tick;
  logic                r_done;

  logic                w_run;
  logic                w_start_go;
  logic                w_count_en;
  logic                w_clr;
  logic                w_pre_wrap;
  logic                w_period_end;
  logic [BITS-1:0]     w_count;
  // The prescaler phase is internal and not exported.
  logic [PRE_BITS-1:0] w_pre_phase_unused;

  assign w_run      = (r_state == ST_RUN);
  // stop always wins over start, so a simultaneous request stays idle.
  assign w_start_go = !w_run && start && !stop;
  // Counting only advances in RUN when neither paused nor aborting.
  assign w_count_en = w_run && !stop && !pause;
  // Counters are held at zero while idle and cleared on abort, so a start
  // always begins from a clean prescaler phase and period count.
  assign w_clr      = !w_run || stop;

  timer_stage_counter #(.W(PRE_BITS)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .top  (r_pre_top),
    .en   (w_count_en),
    .clr  (w_clr),
    .cnt  (w_pre_phase_unused),
    .wrap (w_pre_wrap)
  );

  timer_stage_counter #(.W(BITS)) u_period (
    .clk  (clk),
    .rst  (rst),
    .top  (r_period_top),
    .en   (w_pre_wrap),
    .clr  (w_clr),
    .cnt  (w_count),
    .wrap (w_period_end)
  );

  // FSM, configuration shadow, repeat counter and single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_period_top <= '0;
      r_pre_top    <= '0;
      r_periodic   <= 1'b0;
      r_rep_left   <= '0;
      r_busy       <= 1'b0;
      r_tick       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_start_go) begin
          r_state      <= ST_RUN;
          r_busy       <= 1'b1;
          r_period_top <= cfg_period;
          r_pre_top    <= cfg_prescale;
          r_periodic   <= cfg_periodic;
          // Periodic runs never consume repeats, so rep_left stays at zero.
          r_rep_left   <= cfg_periodic ? '0 : cfg_repeat;
        end
      end else begin
        if (stop) begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_rep_left <= '0;
        end else if (w_period_end) begin
          r_tick <= 1'b1;
          if (!r_periodic) begin
            if (r_rep_left == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_rep_left <= r_rep_left - REP_BITS'(1);
            end
          end
        end
      end
    end
  end

  assign busy      = r_busy;
  assign tick      = r_tick;
  assign done      = r_done;
  assign count_out = w_count;
  assign rep_left  = r_rep_left;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer. Stimulus pushes expected tick events
// (edge number, done flag, rep_left) into a scoreboard; a monitor on the
// falling edge pops and compares whenever tick or done is presented.
module tb_timer_sequencer;

  localparam int BITS     = 16;
  localparam int PRE_BITS = 8;
  localparam int REP_BITS = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [BITS-1:0]     cfg_period = '0;
  logic [PRE_BITS-1:0] cfg_prescale = '0;
  logic [REP_BITS-1:0] cfg_repeat = '0;
  logic                cfg_periodic = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                pause = 1'b0;
  logic                busy;
  logic                tick;
  logic                done;
  logic [BITS-1:0]     count_out;
  logic [REP_BITS-1:0] rep_left;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int edge_n;
    bit done;
    int rep;
  } exp_t;

  exp_t sb[$];

  timer_sequencer #(.BITS(BITS), .PRE_BITS(PRE_BITS), .REP_BITS(REP_BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_repeat   (cfg_repeat),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .count_out    (count_out),
    .rep_left     (rep_left)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_tick(input int e, input bit d, input int r);
    exp_t x;
    x.edge_n = e;
    x.done   = d;
    x.rep    = r;
    sb.push_back(x);
  endtask

  // Advance to 1 time unit after rising edge e.
  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int pre, input int per, input int rep, input bit periodic,
                          output int s);
    @(negedge clk);
    cfg_prescale = PRE_BITS'(pre);
    cfg_period   = BITS'(per);
    cfg_repeat   = REP_BITS'(rep);
    cfg_periodic = periodic;
    start        = 1'b1;
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
    $display("start at edge %0d pre=%0d per=%0d rep=%0d periodic=%0b", s, pre, per, rep, periodic);
  endtask

  // Monitor: every presented tick/done is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (tick || done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick edge=%0d tick=%0b done=%0b required no event", cyc, tick, done);
      end else begin
        e = sb.pop_front();
        $display("tick event edge=%0d tick=%0b done=%0b rep_left=%0d", cyc, tick, done, rep_left);
        chk("tick_edge", 32'(cyc), 32'(e.edge_n));
        chk("tick", 32'(tick), 32'd1);
        chk("done", 32'(done), 32'(e.done));
        chk("rep_left_at_tick", 32'(rep_left), 32'(e.rep));
        chk("count_at_tick", 32'(count_out), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_rep_left", 32'(rep_left), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: prescale 0, period 3, single period
    do_start(0, 3, 0, 1'b0, s);
    expect_tick(s + 4, 1'b1, 0);
    chk("t1_busy_start", 32'(busy), 32'd1);
    wait_edge(s + 3);
    chk("t1_busy_before_end", 32'(busy), 32'd1);
    wait_edge(s + 4);
    chk("t1_busy_after_end", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // 2: prescale 2, period 1, three periods
    do_start(2, 1, 2, 1'b0, s);
    chk("t2_rep_left_start", 32'(rep_left), 32'd2);
    expect_tick(s + 6, 1'b0, 1);
    expect_tick(s + 12, 1'b0, 0);
    expect_tick(s + 18, 1'b1, 0);
    wait_edge(s + 18);
    chk("t2_busy_after_done", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // 3: periodic, prescale 0, period 4, then stop
    do_start(0, 4, 5, 1'b1, s);
    chk("t3_rep_left_periodic", 32'(rep_left), 32'd0);
    for (int k = 1; k <= 6; k++) expect_tick(s + 5 * k, 1'b0, 0);
    wait_edge(s + 32);
    chk("t3_count_mid", 32'(count_out), 32'd2);
    chk("t3_busy_running", 32'(busy), 32'd1);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_busy_after_stop", 32'(busy), 32'd0);
    chk("t3_count_after_stop", 32'(count_out), 32'd0);
    @(negedge clk);
    stop = 1'b0;

    // 4: pause sampled on edges s+3..s+7 delays the tick by 5
    do_start(0, 9, 0, 1'b0, s);
    expect_tick(s + 15, 1'b1, 0);
    wait_edge(s + 2);
    @(negedge clk);
    pause = 1'b1;
    wait_edge(s + 7);
    chk("t4_count_frozen", 32'(count_out), 32'd2);
    @(negedge clk);
    pause = 1'b0;
    wait_edge(s + 14);
    chk("t4_busy_before_end", 32'(busy), 32'd1);
    wait_edge(s + 15);
    chk("t4_busy_after_end", 32'(busy), 32'd0);

    // 5: stop coinciding with period end; start+stop in idle
    do_start(0, 3, 0, 1'b0, s);
    wait_edge(s + 3);
    chk("t5_count_before_end", 32'(count_out), 32'd3);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_tick", 32'(tick), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_count", 32'(count_out), 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_start_stop_idle", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_still_idle", 32'(busy), 32'd0);

    // 6: cfg change during run ignored; async reset mid-run
    do_start(0, 3, 3, 1'b0, s);
    expect_tick(s + 4, 1'b0, 2);
    expect_tick(s + 8, 1'b0, 1);
    @(negedge clk);
    cfg_period = BITS'(7);
    wait_edge(s + 9);
    chk("t6_count_mid", 32'(count_out), 32'd1);
    chk("t6_rep_left_mid", 32'(rep_left), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_count", 32'(count_out), 32'd0);
    chk("t6_rst_rep_left", 32'(rep_left), 32'd0);
    chk("t6_rst_tick", 32'(tick), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_idle_after_rst", 32'(busy), 32'd0);

    // Restart picks up the new period
    do_start(0, 7, 0, 1'b0, s);
    expect_tick(s + 8, 1'b1, 0);
    wait_edge(s + 8);
    chk("t6_busy_after_restart", 32'(busy), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
